systolic_feeder: RTL and testbench

- Transmit side of the MAC processing-element stream interface. Drives the data/valid pairs that the PE grid consumes on its left edge (A rows) and top edge (B columns).
- Holds one NxN operand matrix A and one NxN operand matrix B in internal buffers, loaded over a simple write port.
- On start, emits both matrices as diagonally skewed streams so that A[i][k] and B[k][j] meet in PE(i,j) on the same cycle.
- Sits between the host/load logic and the systolic array.

---
 rtl/systolic_feeder_if.sv | 30 +++
 rtl/systolic_feeder.sv | 126 ++++++++++++
 tb/tb_systolic_feeder.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_if.sv
// Host-to-feeder load/start port and feeder-to-PE-grid skewed stream bundle.
interface systolic_feeder_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8
);
    localparam int unsigned IW = $clog2(N);

    logic              wr_en;
    logic              wr_sel;
    logic [IW-1:0]     wr_row;
    logic [IW-1:0]     wr_col;
    logic [DW-1:0]     wr_data;
    logic              start;
    logic              busy;
    logic              done;
    logic [N*DW-1:0]   a_out;
    logic [N-1:0]      valid_a;
    logic [N*DW-1:0]   b_out;
    logic [N-1:0]      valid_b;

    modport master (
        output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        input  busy, done, a_out, valid_a, b_out, valid_b
    );

    modport slave (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
        output busy, done, a_out, valid_a, b_out, valid_b
    );
endinterface

// File: rtl/systolic_feeder.sv
// Buffers NxN operand matrices A and B and streams them diagonally skewed
// into the left (A rows) and top (B columns) edges of a systolic PE grid.
module systolic_feeder #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8
) (
    input logic               clk,
    input logic               reset,
    systolic_feeder_if.slave  bus
);
    localparam int unsigned IW     = $clog2(N);
    localparam int unsigned TW     = $clog2(2*N-1);
    localparam logic [TW-1:0] T_LAST = TW'(2*N-2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   t, t_nxt;

    logic [DW-1:0]   a_buf  [N][N];
    logic [DW-1:0]   b_buf  [N][N];
    logic [DW-1:0]   a_view [N][N];
    logic [DW-1:0]   b_view [N][N];

    logic [N*DW-1:0] a_q, b_q, a_nxt, b_nxt;
    logic [N-1:0]    va_q, vb_q, va_nxt, vb_nxt;
    logic            wr_ok;

    assign wr_ok = bus.wr_en && (state == IDLE);

    // Operand buffers; writes only land while idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N); i++) begin
                for (int k = 0; k < int'(N); k++) begin
                    a_buf[IW'(i)][IW'(k)] <= '0;
                    b_buf[IW'(i)][IW'(k)] <= '0;
                end
            end
        end else if (wr_ok) begin
            if (bus.wr_sel) b_buf[bus.wr_row][bus.wr_col] <= bus.wr_data;
            else            a_buf[bus.wr_row][bus.wr_col] <= bus.wr_data;
        end
    end

    // Forward a same-edge write so a start on that edge streams the new value
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            for (int k = 0; k < int'(N); k++) begin
                a_view[IW'(i)][IW'(k)] = a_buf[IW'(i)][IW'(k)];
                b_view[IW'(i)][IW'(k)] = b_buf[IW'(i)][IW'(k)];
            end
        end
        if (wr_ok) begin
            if (bus.wr_sel) b_view[bus.wr_row][bus.wr_col] = bus.wr_data;
            else            a_view[bus.wr_row][bus.wr_col] = bus.wr_data;
        end
    end

    // State register and registered stream outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            t     <= '0;
            a_q   <= '0;
            b_q   <= '0;
            va_q  <= '0;
            vb_q  <= '0;
        end else begin
            state <= state_nxt;
            t     <= t_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            va_q  <= va_nxt;
            vb_q  <= vb_nxt;
        end
    end

    // Next state, plus the lane contents for the cycle being entered
    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        a_nxt     = '0;
        b_nxt     = '0;
        va_nxt    = '0;
        vb_nxt    = '0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    t_nxt     = '0;
                end
            end
            RUN: begin
                if (t == T_LAST) begin
                    state_nxt = DONE;
                    t_nxt     = '0;
                end else begin
                    t_nxt = t + TW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Lane i carries element t-i of its row/column during its N-cycle window
        if (state_nxt == RUN) begin
            for (int i = 0; i < int'(N); i++) begin
                if (int'(t_nxt) >= i && int'(t_nxt) <= i + int'(N) - 1) begin
                    va_nxt[IW'(i)]     = 1'b1;
                    vb_nxt[IW'(i)]     = 1'b1;
                    a_nxt[i*DW +: DW]  = a_view[IW'(i)][IW'(int'(t_nxt) - i)];
                    b_nxt[i*DW +: DW]  = b_view[IW'(int'(t_nxt) - i)][IW'(i)];
                end
            end
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.a_out   = a_q;
    assign bus.b_out   = b_q;
    assign bus.valid_a = va_q;
    assign bus.valid_b = vb_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed + randomized bench for systolic_feeder against a matrix-level stream model.
module tb_systolic_feeder;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = $clog2(N);

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];

    systolic_feeder_if #(.N(N), .DW(DW)) bus ();

    systolic_feeder #(.N(N), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int t, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    // Lane i of A shows row i delayed by i cycles; lane j of B shows column j delayed by j
    function automatic logic [N*DW-1:0] exp_a(input int t);
        logic [N*DW-1:0] r = '0;
        for (int i = 0; i < int'(N); i++)
            if (t - i >= 0 && t - i < int'(N)) r[i*DW +: DW] = ma[i][t-i];
        return r;
    endfunction

    function automatic logic [N*DW-1:0] exp_b(input int t);
        logic [N*DW-1:0] r = '0;
        for (int j = 0; j < int'(N); j++)
            if (t - j >= 0 && t - j < int'(N)) r[j*DW +: DW] = mb[t-j][j];
        return r;
    endfunction

    function automatic logic [N-1:0] exp_v(input int t);
        logic [N-1:0] r = '0;
        for (int i = 0; i < int'(N); i++)
            if (t - i >= 0 && t - i < int'(N)) r[i] = 1'b1;
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < int'(N); i++)
            for (int k = 0; k < int'(N); k++) begin
                ma[i][k] = '0;
                mb[i][k] = '0;
            end
    endtask

    task automatic wr(input bit sel, input int r, input int c, input logic [DW-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_row  = IW'(r);
        bus.wr_col  = IW'(c);
        bus.wr_data = d;
        @(posedge clk); #1;
        bus.wr_en   = 1'b0;
        if (sel) mb[r][c] = d;
        else     ma[r][c] = d;
    endtask

    task automatic check_idle(input string tag, input int t);
        chk({tag, ".busy"}, t, 64'(bus.busy), 64'(0));
        chk({tag, ".done"}, t, 64'(bus.done), 64'(0));
        chk({tag, ".va"},   t, 64'(bus.valid_a), 64'(0));
        chk({tag, ".vb"},   t, 64'(bus.valid_b), 64'(0));
        chk({tag, ".a"},    t, 64'(bus.a_out), 64'(0));
        chk({tag, ".b"},    t, 64'(bus.b_out), 64'(0));
    endtask

    task automatic inject_junk();
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'($urandom_range(0, 1));
        bus.wr_row  = IW'($urandom_range(0, N-1));
        bus.wr_col  = IW'($urandom_range(0, N-1));
        bus.wr_data = 8'hFF;
    endtask

    // Start a run (optionally with a same-edge write of A[0][0]) and check every cycle
    task automatic run_chk(input string tag, input bit inject, input bit same_wr, input logic [DW-1:0] same_data);
        if (same_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 1'b0;
            bus.wr_row  = '0;
            bus.wr_col  = '0;
            bus.wr_data = same_data;
            ma[0][0]    = same_data;
        end
        bus.start = 1'b1;
        for (int t = 0; t < int'(2*N-1); t++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            chk({tag, ".va"},   t, 64'(bus.valid_a), 64'(exp_v(t)));
            chk({tag, ".vb"},   t, 64'(bus.valid_b), 64'(exp_v(t)));
            chk({tag, ".a"},    t, 64'(bus.a_out),   64'(exp_a(t)));
            chk({tag, ".b"},    t, 64'(bus.b_out),   64'(exp_b(t)));
            chk({tag, ".busy"}, t, 64'(bus.busy),    64'(1));
            chk({tag, ".done"}, t, 64'(bus.done),    64'(0));
            if (inject && t == 1) inject_junk();
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        chk({tag, ".done_pulse"}, 2*N-1, 64'(bus.done), 64'(1));
        chk({tag, ".done_busy"},  2*N-1, 64'(bus.busy), 64'(1));
        chk({tag, ".done_va"},    2*N-1, 64'(bus.valid_a), 64'(0));
        chk({tag, ".done_a"},     2*N-1, 64'(bus.a_out), 64'(0));
        if (inject) inject_junk();
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        check_idle({tag, ".post"}, 2*N);
    endtask

    initial begin
        clk         = 1'b0;
        reset       = 1'b1;
        total       = 0;
        bad         = 0;
        bus.wr_en   = 1'b0;
        bus.wr_sel  = 1'b0;
        bus.wr_row  = '0;
        bus.wr_col  = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        clear_model();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset", 0);
        reset = 1'b0;

        // Reset during load wipes the buffer
        wr(1'b0, 1, 2, 8'd9);
        #2 reset = 1'b1;
        #1 check_idle("rst_load", 0);
        clear_model();
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        run_chk("zero_after_rst", 1'b0, 1'b0, '0);

        // Basic skew pattern
        for (int i = 0; i < int'(N); i++)
            for (int k = 0; k < int'(N); k++) begin
                wr(1'b0, i, k, DW'(4*i + k + 1));
                wr(1'b1, i, k, DW'(4*i + k + 17));
            end
        run_chk("basic", 1'b0, 1'b0, '0);

        // Starts and writes while busy are ignored; replays back to back
        run_chk("ignore", 1'b1, 1'b0, '0);
        run_chk("replay", 1'b0, 1'b0, '0);
        run_chk("b2b", 1'b0, 1'b0, '0);

        // Same-edge write and start
        run_chk("same_edge", 1'b0, 1'b1, 8'h5A);

        // Randomized matrices
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < int'(N); i++)
                for (int k = 0; k < int'(N); k++) begin
                    wr(1'b0, i, k, DW'($urandom));
                    wr(1'b1, i, k, DW'($urandom));
                end
            run_chk("random", 1'b0, 1'b0, '0);
        end

        // Reset mid-run at t=3
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("midrun.busy_pre", 3, 64'(bus.busy), 64'(1));
        #1 reset = 1'b1;
        #1 check_idle("midrun", 3);
        @(posedge clk); #1;
        check_idle("midrun_hold", 4);
        clear_model();
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        run_chk("zero_after_midrun", 1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
